ipv4_opt_filter: RTL

- Packet-path stage placed directly upstream of the crypto stage in the user data path.
- Drops IPv4 packets that carry IP options (IHL != 5). The crypto stage assumes a fixed 34-byte Ethernet+IP header and would corrupt the payload offset for such packets.
- All other packets pass unmodified.
- Keeps pass and drop counters on the register ring.

---
 rtl/ipv4_opt_filter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ipv4_opt_filter.sv
// Drops IPv4 packets carrying IP options ahead of the crypto stage; pass/drop counters on the register ring.
// Optional: define IPV4_OPT_FILTER_NONIP_DROP_EN to also drop non-IPv4 and sub-2-word packets.
`ifndef IPV4_OPT_FILTER_BLOCK_ADDR
`define IPV4_OPT_FILTER_BLOCK_ADDR 22'h2a0001
`endif

module ipv4_opt_filter #(
  parameter int DATA_WIDTH          = 64,
  parameter int CTRL_WIDTH          = DATA_WIDTH/8,
  parameter int UDP_REG_SRC_WIDTH   = 2,
  parameter int MAX_HDR_WORDS       = 4,
  parameter int UDP_REG_ADDR_WIDTH  = 23,
  parameter int CPCI_NF2_DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [CTRL_WIDTH-1:0]          in_ctrl,
  input  logic                           in_wr,
  output logic                           in_rdy,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out
);

  localparam int WW    = CTRL_WIDTH + DATA_WIDTH;
  localparam int BW    = $clog2(MAX_HDR_WORDS + 1);
  localparam int IW    = $clog2(MAX_HDR_WORDS);
  localparam int TAG_W = UDP_REG_ADDR_WIDTH - 1;
  localparam logic [BW-1:0]                  B_ONE     = 1;
  localparam logic [BW-1:0]                  B_LAST    = BW'(MAX_HDR_WORDS - 1);
  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] C_ONE     = 1;
  localparam logic [TAG_W-1:0]               BLOCK_TAG = TAG_W'(`IPV4_OPT_FILTER_BLOCK_ADDR);

  typedef enum logic [1:0] {COLLECT, FLUSH, PASS, DROP} state_t;

  state_t state, state_n;

  // Input fallthrough FIFO, 4 deep
  logic [WW-1:0]         fifo_mem [4];
  logic [1:0]            fifo_wp, fifo_rp;
  logic [2:0]            fifo_cnt;
  logic                  fifo_empty, fifo_we, pop;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;

  assign {head_ctrl, head_data} = fifo_mem[fifo_rp];
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign in_rdy     = (fifo_cnt < 3'd3);
  assign fifo_we    = in_wr && (fifo_cnt != 3'd4);

  always_ff @(posedge clk) begin
    if (fifo_we) fifo_mem[fifo_wp] <= {in_ctrl, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_we) fifo_wp <= fifo_wp + 2'd1;
      if (pop)     fifo_rp <= fifo_rp + 2'd1;
      fifo_cnt <= fifo_cnt + (fifo_we ? 3'd1 : 3'd0) - (pop ? 3'd1 : 3'd0);
    end
  end

  // Decision buffer and output register
  logic [WW-1:0]                  hbuf [MAX_HDR_WORDS];
  logic [BW-1:0]                  bcnt, ridx;
  logic [1:0]                     dcnt;
  logic                           complete, out_valid, out_eop, ld_ok;
  logic                           buf_wr, buf_clr, set_complete, ld_buf, ld_fifo, ld_eop, drop_pulse;
  logic                           is_ip, bad_opt, drop_hdr;
  logic [CPCI_NF2_DATA_WIDTH-1:0] pass_cnt, drop_cnt;

  assign is_ip   = (head_data[31:16] == 16'h0800);
  assign bad_opt = (head_data[15:12] != 4'd4) || (head_data[11:8] != 4'd5);
`ifdef IPV4_OPT_FILTER_NONIP_DROP_EN
  assign drop_hdr = !is_ip || bad_opt;
`else
  assign drop_hdr = is_ip && bad_opt;
`endif

  // The output stage is a one-entry register; it refills when empty or being taken
  assign out_wr = out_valid && out_rdy;
  assign ld_ok  = !out_valid || out_rdy;

  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    buf_wr       = 1'b0;
    buf_clr      = 1'b0;
    set_complete = 1'b0;
    ld_buf       = 1'b0;
    ld_fifo      = 1'b0;
    ld_eop       = 1'b0;
    drop_pulse   = 1'b0;
    unique case (state)
      COLLECT: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          buf_wr = 1'b1;
          if (head_ctrl == '0 && dcnt == 2'd1) begin
            if (drop_hdr) begin
              state_n    = DROP;
              drop_pulse = 1'b1;
              buf_clr    = 1'b1;
            end else begin
              state_n = FLUSH;
            end
          end else if (head_ctrl != '0 && dcnt != 2'd0) begin
`ifdef IPV4_OPT_FILTER_NONIP_DROP_EN
            drop_pulse = 1'b1;
            buf_clr    = 1'b1;
`else
            set_complete = 1'b1;
            state_n      = FLUSH;
`endif
          end else if (bcnt == B_LAST) begin
            state_n = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (ld_ok && ridx != bcnt) begin
          ld_buf = 1'b1;
          if (ridx == bcnt - B_ONE) begin
            ld_eop  = complete;
            buf_clr = 1'b1;
            state_n = complete ? COLLECT : PASS;
          end
        end
      end
      PASS: begin
        if (ld_ok && !fifo_empty) begin
          pop     = 1'b1;
          ld_fifo = 1'b1;
          if (head_ctrl != '0) begin
            ld_eop  = 1'b1;
            state_n = COLLECT;
          end
        end
      end
      DROP: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_ctrl != '0) state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (buf_wr) hbuf[bcnt[IW-1:0]] <= {head_ctrl, head_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      bcnt      <= '0;
      ridx      <= '0;
      dcnt      <= '0;
      complete  <= 1'b0;
      out_valid <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      pass_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_n;
      if (buf_clr) begin
        bcnt     <= '0;
        ridx     <= '0;
        dcnt     <= '0;
        complete <= 1'b0;
      end else begin
        if (buf_wr) begin
          bcnt <= bcnt + B_ONE;
          if (head_ctrl == '0 && dcnt != 2'd2) dcnt <= dcnt + 2'd1;
        end
        if (ld_buf)       ridx     <= ridx + B_ONE;
        if (set_complete) complete <= 1'b1;
      end
      if (ld_buf || ld_fifo) begin
        out_valid              <= 1'b1;
        out_eop                <= ld_eop;
        {out_ctrl, out_data}   <= ld_buf ? hbuf[ridx[IW-1:0]] : {head_ctrl, head_data};
      end else if (out_wr) begin
        out_valid <= 1'b0;
      end
      if (out_wr && out_eop) pass_cnt <= pass_cnt + C_ONE;
      if (drop_pulse)        drop_cnt <= drop_cnt + C_ONE;
    end
  end

  // Register ring: offset 0 = passed, offset 1 = dropped; writes are acked and ignored
  logic reg_hit;
  assign reg_hit = reg_req_in && !reg_ack_in &&
                   (reg_addr_in[UDP_REG_ADDR_WIDTH-1:1] == BLOCK_TAG);

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      if (reg_hit) begin
        reg_ack_out  <= 1'b1;
        reg_data_out <= reg_rd_wr_L_in ? (reg_addr_in[0] ? drop_cnt : pass_cnt) : reg_data_in;
      end else begin
        reg_ack_out  <= reg_ack_in;
        reg_data_out <= reg_data_in;
      end
    end
  end

endmodule
